// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer: capture modes, controller states
// and the packed retirement record.
package ibex_trace_pkg;

    localparam int unsigned TraceOrderWidth = 16;
    localparam int unsigned DropCntWidth    = 16;

    typedef enum logic {
        TraceStream = 1'b0,
        TraceWindow = 1'b1
    } trace_mode_e;

    typedef enum logic [1:0] {
        TrIdle   = 2'd0,
        TrArmed  = 2'd1,
        TrPost   = 2'd2,
        TrFrozen = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [TraceOrderWidth-1:0] order;
        logic [31:0]                pc;
        logic [31:0]                insn;
        logic [4:0]                 rd_addr;
        logic [31:0]                rd_wdata;
        logic                       trap;
        logic                       intr;
    } trace_rec_t;

endpackage

// File: rtl/ibex_trace_fifo.sv
// Record storage with head/tail pointers and a fill level. A push into a full
// buffer either evicts the oldest entry (overwrite_i) or is rejected.
module ibex_trace_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned LvlW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             overwrite_i,
    input  logic             pop_i,
    output logic             push_accepted_o,
    output logic [Width-1:0] head_data_o,
    output logic [LvlW-1:0]  level_o
);

    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [Width-1:0] mem_q [Depth];
    logic             empty, full, pop_ok, push_ok, head_adv;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == LvlW'(Depth));
        pop_ok   = pop_i && !empty;
        push_ok  = push_i && !flush_i && (!full || pop_ok || overwrite_i);
        // An accepted push into a full buffer without a pop evicts the head.
        head_adv = pop_ok || (push_ok && full);
        head_d   = head_q;
        tail_d   = tail_q;
        level_d  = level_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok)  tail_d = tail_q + 1'b1;
            if (head_adv) head_d = head_q + 1'b1;
            case ({push_ok, head_adv})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[tail_q] <= push_data_i;
    end

    assign push_accepted_o = push_ok;
    assign head_data_o     = empty ? '0 : mem_q[head_q];
    assign level_o         = level_q;

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// On-chip capture of RVFI retirement records: lossy stream FIFO or
// trigger-centred window capture, drained through a valid/ready read port.
module ibex_rvfi_trace_buffer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth       = 16,
    parameter int unsigned PostTrigger = 8,
    parameter int unsigned OrderWidth  = 16,
    localparam int unsigned LvlW = $clog2(Depth + 1),
    localparam int unsigned CntW = $clog2(Depth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rvfi_valid_i,
    input  logic [63:0]                   rvfi_order_i,
    input  logic [31:0]                   rvfi_pc_rdata_i,
    input  logic [31:0]                   rvfi_insn_i,
    input  logic                          rvfi_trap_i,
    input  logic                          rvfi_intr_i,
    input  logic [4:0]                    rvfi_rd_addr_i,
    input  logic [31:0]                   rvfi_rd_wdata_i,
    input  logic                          mode_i,
    input  logic                          arm_i,
    input  logic                          disarm_i,
    input  logic                          clear_i,
    input  logic                          trig_en_i,
    input  logic [31:0]                   trig_pc_i,
    input  logic                          trig_on_trap_i,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [$bits(trace_rec_t)-1:0] rd_data_o,
    output logic [LvlW-1:0]               level_o,
    output logic [DropCntWidth-1:0]       drop_cnt_o,
    output logic [1:0]                    state_o,
    output logic                          triggered_o
);

    trace_state_e            state_q, state_d;
    trace_mode_e             mode_q, mode_d;
    logic [CntW-1:0]         post_cnt_q, post_cnt_d;
    logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
    logic                    triggered_q, triggered_d;
    logic                    ctrl_pulse, capture_en, trigger_hit, flush;
    logic                    push_accepted, read_allowed, pop;
    logic                    unused_order;
    trace_rec_t              rec_in;

    assign unused_order = ^rvfi_order_i;

    always_comb begin
        rec_in.order    = TraceOrderWidth'(rvfi_order_i[OrderWidth-1:0]);
        rec_in.pc       = rvfi_pc_rdata_i;
        rec_in.insn     = rvfi_insn_i;
        rec_in.rd_addr  = rvfi_rd_addr_i;
        rec_in.rd_wdata = rvfi_rd_wdata_i;
        rec_in.trap     = rvfi_trap_i;
        rec_in.intr     = rvfi_intr_i;
    end

    // Any control pulse suppresses the retirement sampled on the same edge.
    assign ctrl_pulse  = clear_i || arm_i || disarm_i;
    assign capture_en  = rvfi_valid_i && !ctrl_pulse &&
                         (state_q == TrArmed || state_q == TrPost);
    assign trigger_hit = rvfi_valid_i &&
                         ((trig_en_i && (rvfi_pc_rdata_i == trig_pc_i)) ||
                          (trig_on_trap_i && rvfi_trap_i));
    assign flush       = clear_i || arm_i;

    ibex_trace_fifo #(
        .Depth (Depth),
        .Width ($bits(trace_rec_t))
    ) u_fifo (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush),
        .push_i          (capture_en),
        .push_data_i     (rec_in),
        .overwrite_i     (mode_q == TraceWindow),
        .pop_i           (pop),
        .push_accepted_o (push_accepted),
        .head_data_o     (rd_data_o),
        .level_o         (level_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= TrIdle;
            mode_q      <= TraceStream;
            post_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            post_cnt_q  <= post_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            triggered_q <= triggered_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        if (clear_i) begin
            state_d = TrIdle;
        end else if (arm_i) begin
            state_d     = TrArmed;
            mode_d      = trace_mode_e'(mode_i);
            triggered_d = 1'b0;
        end else if (disarm_i) begin
            if (state_q == TrArmed || state_q == TrPost) state_d = TrIdle;
        end else if (capture_en) begin
            case (state_q)
                TrArmed: begin
                    if (mode_q == TraceWindow && trigger_hit) begin
                        triggered_d = 1'b1;
                        post_cnt_d  = CntW'(PostTrigger);
                        state_d     = (PostTrigger == 0) ? TrFrozen : TrPost;
                    end
                end
                TrPost: begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == CntW'(1)) state_d = TrFrozen;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (!clear_i && arm_i) begin
            drop_cnt_d = '0;
        end else if (capture_en && mode_q == TraceStream && !push_accepted &&
                     drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Window captures are only readable once capture has stopped.
    always_comb begin
        read_allowed = (mode_q == TraceStream) || (state_q == TrIdle) ||
                       (state_q == TrFrozen);
        rd_valid_o   = (level_o != '0) && read_allowed;
        state_o      = state_q;
    end

    assign pop         = rd_valid_o && rd_ready_i;
    assign drop_cnt_o  = drop_cnt_q;
    assign triggered_o = triggered_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed bench for the RVFI trace buffer with a read-side scoreboard per DUT.
module tb_ibex_rvfi_trace_buffer;
    import ibex_trace_pkg::*;

    localparam int RecW = $bits(trace_rec_t);

    logic            clk, rst_n;
    logic            rvfi_valid, trap, intr, mode, arm, arm0, disarm, clear;
    logic            trig_en, trig_on_trap, rd_ready, rd_ready0;
    logic [63:0]     order;
    logic [31:0]     pc, insn, rd_wdata, trig_pc;
    logic [4:0]      rd_addr;
    logic            rd_valid, triggered, rd_valid0, triggered0;
    logic [RecW-1:0] rd_data, rd_data0;
    logic [4:0]      level, level0;
    logic [15:0]     drop, drop0;
    logic [1:0]      state, state0;

    int errors = 0;
    int checks = 0;
    logic [RecW-1:0] exp_q[$];
    logic [RecW-1:0] exp0_q[$];

    ibex_rvfi_trace_buffer #(.Depth(16), .PostTrigger(8), .OrderWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(rvfi_valid), .rvfi_order_i(order),
        .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr),
        .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(rd_wdata), .mode_i(mode), .arm_i(arm),
        .disarm_i(disarm), .clear_i(clear), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .trig_on_trap_i(trig_on_trap), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .rd_data_o(rd_data), .level_o(level), .drop_cnt_o(drop), .state_o(state),
        .triggered_o(triggered));

    ibex_rvfi_trace_buffer #(.Depth(16), .PostTrigger(0), .OrderWidth(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(rvfi_valid), .rvfi_order_i(order),
        .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn), .rvfi_trap_i(trap), .rvfi_intr_i(intr),
        .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(rd_wdata), .mode_i(mode), .arm_i(arm0),
        .disarm_i(disarm), .clear_i(clear), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .trig_on_trap_i(trig_on_trap), .rd_valid_o(rd_valid0), .rd_ready_i(rd_ready0),
        .rd_data_o(rd_data0), .level_o(level0), .drop_cnt_o(drop0), .state_o(state0),
        .triggered_o(triggered0));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [RecW-1:0] mk_rec(int unsigned ord, logic [31:0] pc_v, logic trap_v);
        trace_rec_t r;
        logic [31:0] o32;
        o32        = ord;
        r.order    = o32[15:0];
        r.pc       = pc_v;
        r.insn     = 32'hA000_0000 | o32;
        r.rd_addr  = o32[4:0];
        r.rd_wdata = o32 ^ 32'h5A5A_5A5A;
        r.trap     = trap_v;
        r.intr     = o32[0];
        return r;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Driver tasks: each returns 1 time unit after a rising edge.
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic retire(int unsigned ord, logic [31:0] pc_v, logic trap_v);
        logic [31:0] o32;
        o32        = ord;
        rvfi_valid = 1'b1;
        order      = {32'h0, o32};
        pc         = pc_v;
        insn       = 32'hA000_0000 | o32;
        rd_addr    = o32[4:0];
        rd_wdata   = o32 ^ 32'h5A5A_5A5A;
        trap       = trap_v;
        intr       = o32[0];
        tick(1);
        rvfi_valid = 1'b0;
        trap       = 1'b0;
    endtask

    task automatic do_arm(logic m, bit which);
        mode = m;
        if (which) arm0 = 1'b1;
        else       arm  = 1'b1;
        tick(1);
        arm  = 1'b0;
        arm0 = 1'b0;
    endtask

    task automatic drain(bit which);
        if (which) rd_ready0 = 1'b1;
        else       rd_ready  = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if ((which ? level0 : level) == 5'd0) break;
            tick(1);
        end
        rd_ready  = 1'b0;
        rd_ready0 = 1'b0;
        check("drain_level", which ? level0 : level, 0);
        check("drain_queue_left", which ? exp0_q.size() : exp_q.size(), 0);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got %0h expected no record", rd_data);
            end else begin
                logic [RecW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid0 && rd_ready0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data0: got %0h expected no record", rd_data0);
            end else begin
                logic [RecW-1:0] e;
                e = exp0_q.pop_front();
                if (rd_data0 !== e) begin
                    errors++;
                    $display("FAIL rd_data0: got %0h expected %0h", rd_data0, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; rvfi_valid = 1'b0; order = '0; pc = '0; insn = '0; trap = 1'b0;
        intr = 1'b0; rd_addr = '0; rd_wdata = '0; mode = 1'b0; arm = 1'b0; arm0 = 1'b0;
        disarm = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0; trig_on_trap = 1'b0;
        rd_ready = 1'b0; rd_ready0 = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        check("rst_state", state, 0);
        check("rst_level", level, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_drop", drop, 0);
        check("rst_triggered", triggered, 0);

        // Stream basic, consumer always ready
        rd_ready = 1'b1;
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk_rec(i, 32'h100 + 4 * i, 1'b0));
            retire(i, 32'h100 + 4 * i, 1'b0);
        end
        tick(3);
        rd_ready = 1'b0;
        check("basic_level", level, 0);
        check("basic_drop", drop, 0);
        check("basic_queue_left", exp_q.size(), 0);

        // Stream overflow: 20 retirements into 16 entries
        do_arm(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(mk_rec(i, 32'h1000 + 4 * i, 1'b0));
            retire(i, 32'h1000 + 4 * i, 1'b0);
        end
        check("ovf_level", level, 16);
        check("ovf_drop", drop, 4);
        check("ovf_state", state, 1);
        drain(1'b0);

        // Full buffer with simultaneous push and pop
        do_arm(1'b0, 1'b0);
        check("rearm_drop", drop, 0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(mk_rec(i, 32'h2000 + 4 * i, 1'b0));
            retire(i, 32'h2000 + 4 * i, 1'b0);
        end
        check("pp_level_before", level, 16);
        exp_q.push_back(mk_rec(16, 32'h2040, 1'b0));
        rd_ready = 1'b1;
        retire(16, 32'h2040, 1'b0);
        rd_ready = 1'b0;
        check("pp_drop", drop, 0);
        check("pp_level_after", level, 16);
        drain(1'b0);

        // Window capture around a PC trigger at order 40
        trig_en = 1'b1;
        trig_pc = 32'h200;
        do_arm(1'b1, 1'b0);
        for (int i = 0; i < 49; i++) begin
            logic [31:0] p;
            p = (i == 40) ? 32'h200 : 32'h3000 + 4 * i;
            if (i >= 33) exp_q.push_back(mk_rec(i, p, 1'b0));
            retire(i, p, 1'b0);
            if (i == 20) check("win_armed_rd_valid", rd_valid, 0);
            if (i == 40) begin
                check("win_post_state", state, 2);
                check("win_post_triggered", triggered, 1);
            end
        end
        check("win_frozen_state", state, 3);
        check("win_frozen_level", level, 16);
        check("win_triggered", triggered, 1);
        retire(49, 32'h3000 + 4 * 49, 1'b0);
        check("win_ignored_level", level, 16);
        drain(1'b0);
        trig_en = 1'b0;

        // Trap trigger with no post-trigger records
        trig_on_trap = 1'b1;
        do_arm(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            exp0_q.push_back(mk_rec(i, 32'h5000 + 4 * i, i == 5));
            retire(i, 32'h5000 + 4 * i, i == 5);
        end
        check("trap_state", state0, 3);
        check("trap_level", level0, 6);
        check("trap_triggered", triggered0, 1);
        retire(6, 32'h5018, 1'b0);
        check("trap_ignored_level", level0, 6);
        drain(1'b1);
        trig_on_trap = 1'b0;

        // Clear beats arm while in POST
        trig_en = 1'b1;
        trig_pc = 32'h200;
        do_arm(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) retire(i, 32'h4000 + 4 * i, 1'b0);
        retire(4, 32'h200, 1'b0);
        check("prio_post_state", state, 2);
        clear = 1'b1;
        arm   = 1'b1;
        mode  = 1'b0;
        tick(1);
        clear = 1'b0;
        arm   = 1'b0;
        check("prio_state", state, 0);
        check("prio_level", level, 0);

        // Asynchronous reset in the middle of POST
        do_arm(1'b1, 1'b0);
        retire(0, 32'h200, 1'b0);
        retire(1, 32'h4004, 1'b0);
        check("mid_post_state", state, 2);
        check("mid_post_level", level, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_level", level, 0);
        check("arst_drop", drop, 0);
        check("arst_triggered", triggered, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_rd_data", rd_data, 0);
        tick(1);
        rst_n = 1'b1;
        trig_en = 1'b0;
        tick(2);

        check("final_queue", exp_q.size(), 0);
        check("final_queue0", exp0_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
